// File: rtl/linemac_acc_pe.sv
// linemac_acc_pe: spike x attention line-accumulate PE.
// Sums num_lines lines column-wise into a line buffer, then drains it.
module linemac_acc_pe #(
  parameter int TIME_STEPS = 4,
  parameter int ATTN_W     = 4,
  parameter int PSUM_W     = 12,
  parameter int LINE_LEN   = 64,
  parameter int LINES_W    = 8,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         s_clk,
  input  logic                         s_rst_n,
  input  logic                         i_start,
  input  logic [LINES_W-1:0]           i_num_lines,
  input  logic                         i_data_valid,
  output logic                         o_data_ready,
  input  logic [TIME_STEPS-1:0]        i_value_spikes,
  input  logic [ATTN_W*TIME_STEPS-1:0] i_attn_data,
  output logic                         o_psum_valid,
  input  logic                         i_psum_ready,
  output logic [PSUM_W*TIME_STEPS-1:0] o_psum_data,
  output logic                         o_psum_last,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_sat_flag
);

  localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LW = PSUM_W * TIME_STEPS;
  localparam logic [CW-1:0] COL_MAX = CW'(LINE_LEN - 1);
  localparam logic [PSUM_W-1:0] P_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] P_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_ACCUM,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t             state;
  logic [CW-1:0]      col;
  logic [CW-1:0]      rd_ptr;
  logic [LINES_W-1:0] line;
  logic [LINES_W-1:0] last_line;
  logic               flush_cnt;
  logic               drain_pend;

  logic [LW-1:0]      mem [LINE_LEN];

  logic               accept;
  logic               col_last;
  logic               line_last;
  logic [LW-1:0]      prod;

  logic               s1_vld;
  logic               s1_acc;
  logic [CW-1:0]      s1_col;
  logic [LW-1:0]      s1_prod;
  logic [LW-1:0]      rd_q;

  logic [LW-1:0]      base;
  logic [LW-1:0]      wr_data;
  logic [PSUM_W:0]    sx;
  logic               clip_any;

  assign o_data_ready = (state == S_FIRST) || (state == S_ACCUM);
  assign o_busy       = (state != S_IDLE);
  assign accept       = i_data_valid && o_data_ready;
  assign col_last     = (col == COL_MAX);
  assign line_last    = (line == last_line);

  always_comb begin
    prod = '0;
    for (int t = 0; t < TIME_STEPS; t++) begin
      if (i_value_spikes[t]) begin
        prod[t*PSUM_W +: PSUM_W] = {
          {(PSUM_W-ATTN_W){i_attn_data[t*ATTN_W+ATTN_W-1]}},
          i_attn_data[t*ATTN_W +: ATTN_W]
        };
      end
    end
  end

  // Stage 1: capture product, read old column sum for ACCUM
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      s1_vld  <= 1'b0;
      s1_acc  <= 1'b0;
      s1_col  <= '0;
      s1_prod <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_acc  <= (state == S_ACCUM);
        s1_col  <= col;
        s1_prod <= prod;
      end
    end
  end

  // Stage 2: per-lane add with optional clipping
  always_comb begin
    base     = s1_acc ? rd_q : '0;
    wr_data  = '0;
    clip_any = 1'b0;
    sx       = '0;
    for (int t = 0; t < TIME_STEPS; t++) begin
      sx = {base[t*PSUM_W+PSUM_W-1], base[t*PSUM_W +: PSUM_W]}
         + {s1_prod[t*PSUM_W+PSUM_W-1], s1_prod[t*PSUM_W +: PSUM_W]};
      if (SATURATE && (sx[PSUM_W] != sx[PSUM_W-1])) begin
        wr_data[t*PSUM_W +: PSUM_W] = sx[PSUM_W] ? P_MIN : P_MAX;
        clip_any = 1'b1;
      end else begin
        wr_data[t*PSUM_W +: PSUM_W] = sx[PSUM_W-1:0];
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (s1_vld) mem[s1_col] <= wr_data;
    if (accept) rd_q <= mem[col];
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      state        <= S_IDLE;
      col          <= '0;
      line         <= '0;
      last_line    <= '0;
      flush_cnt    <= 1'b0;
      rd_ptr       <= '0;
      drain_pend   <= 1'b0;
      o_psum_valid <= 1'b0;
      o_psum_last  <= 1'b0;
      o_psum_data  <= '0;
      o_done       <= 1'b0;
      o_sat_flag   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (s1_vld && clip_any) o_sat_flag <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            state      <= S_FIRST;
            col        <= '0;
            line       <= '0;
            o_sat_flag <= 1'b0;
            last_line  <= (i_num_lines == '0) ? '0
                        : i_num_lines - LINES_W'(1);
          end
        end
        S_FIRST, S_ACCUM: begin
          if (accept) begin
            col <= col_last ? '0 : col + CW'(1);
            if (col_last) begin
              line <= line + LINES_W'(1);
              if (line_last) begin
                state     <= S_FLUSH;
                flush_cnt <= 1'b0;
              end else begin
                state <= S_ACCUM;
              end
            end
          end
        end
        S_FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            state      <= S_DRAIN;
            rd_ptr     <= '0;
            drain_pend <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (o_psum_valid && i_psum_ready && o_psum_last) begin
            state        <= S_IDLE;
            o_psum_valid <= 1'b0;
            o_psum_last  <= 1'b0;
            o_done       <= 1'b1;
          end else if (!o_psum_valid || i_psum_ready) begin
            if (drain_pend) begin
              o_psum_valid <= 1'b1;
              o_psum_data  <= mem[rd_ptr];
              o_psum_last  <= (rd_ptr == COL_MAX);
              rd_ptr       <= (rd_ptr == COL_MAX) ? '0 : rd_ptr + CW'(1);
              if (rd_ptr == COL_MAX) drain_pend <= 1'b0;
            end else begin
              o_psum_valid <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/linemac_acc_pe.md
# linemac_acc_pe

Parametrised spike × attention line-accumulate PE with an internal line buffer and a drain handshake. Each input beat masks TIME_STEPS signed attention lanes with the matching value spikes. It accumulates the result column-wise over `num_lines` lines into an on-chip buffer of LINE_LEN entries, then streams the finished line out over a valid/ready port. It sits in the attention-multiply-spikes path, one instance per systolic output column.

## Interface
- TIME_STEPS, 4, number of spike time steps (lanes per beat)
- ATTN_W, 4, signed width of one attention lane
- PSUM_W, 12, signed width of one accumulated lane (≥ ATTN_W+1)
- LINE_LEN, 64, beats per line = buffer depth (≥ 4)
- LINES_W, 8, width of the line-count input
- SATURATE, 1, 1 = saturating add, 0 = two's-complement wrap
- s_clk  in  1  clock; every register is clocked on its rising edge
- s_rst_n  in  1  reset; synchronous, active-low
- i_start  in  1  job start pulse; accepted only in IDLE
- i_num_lines  in  LINES_W  lines to accumulate; latched at accepted i_start; 0 is treated as 1
- i_data_valid  in  1  input beat valid
- o_data_ready  out  1  input beat ready
- i_value_spikes  in  TIME_STEPS  spike bit per lane
- i_attn_data  in  ATTN_W*TIME_STEPS  signed attention lanes; lane t is at [t*ATTN_W +: ATTN_W]
- o_psum_valid  out  1  result beat valid
- i_psum_ready  in  1  result beat ready
- o_psum_data  out  PSUM_W*TIME_STEPS  accumulated lanes; same packing as i_attn_data
- o_psum_last  out  1  asserted with the final result beat (column LINE_LEN-1)
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse after the last result beat is accepted
- o_sat_flag  out  1  sticky: any lane clipped during the current job; cleared at accepted i_start

## Operation
- States:
  - IDLE → FIRST on i_start.
  - FIRST → ACCUM when the last beat of line 0 is accepted and num_lines > 1.
  - FIRST or ACCUM → FLUSH when the last beat of the last line is accepted.
  - FLUSH → DRAIN after 2 cycles (pipeline empty).
  - DRAIN → IDLE when the beat carrying o_psum_last is accepted.
- o_data_ready = (state == FIRST || state == ACCUM). A beat is accepted on i_data_valid && o_data_ready.
- Column counter col runs 0..LINE_LEN-1, advances per accepted beat and wraps at LINE_LEN. The line counter increments on each wrap.
- Product lane t = i_value_spikes[t] ? sext(i_attn_data lane t) : 0.
- FIRST: buffer[col] ← product; the buffer is not read, so stale contents are irrelevant.
- ACCUM: buffer[col] ← buffer[col] + product, per lane. The read has 1-cycle latency; the write commits in stage 2.
- Arithmetic: PSUM_W signed per lane. With SATURATE=1, clip to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1] and set o_sat_flag. With SATURATE=0, wrap and never set o_sat_flag.
- DRAIN: buffer read in column order 0..LINE_LEN-1. o_psum_data and o_psum_last must hold stable while o_psum_valid && !i_psum_ready. No beat is dropped or duplicated.
- i_start outside IDLE is ignored. i_data_valid outside FIRST/ACCUM is ignored.
- Reset mid-operation: return to IDLE with all outputs at their reset values. Buffer contents are not cleared.

## Timing
- Reset values: o_data_ready=0, o_psum_valid=0, o_psum_last=0, o_psum_data=0, o_busy=0, o_done=0, o_sat_flag=0.
- i_start sampled in cycle n: state=FIRST and o_data_ready=1 in cycle n+1.
- Accumulate pipeline: accepted at n, buffer written at n+2. Same-column reuse is ≥ LINE_LEN ≥ 4 cycles apart, so there is no read-after-write hazard.
- The last beat accepted at n gives o_data_ready=0 from n+1 (FLUSH at n+1..n+2) and DRAIN at n+3.
- o_psum_valid asserts no later than 2 cycles after DRAIN entry.
- With i_psum_ready held high, output runs at 1 beat/cycle: LINE_LEN consecutive beats.
- o_done pulses the cycle after the o_psum_last beat is accepted, coincident with o_busy falling.
- Input throughput is 1 beat/cycle; gaps in i_data_valid stall col with no effect on results.

## Test plan
- TIME_STEPS=4, ATTN_W=4, PSUM_W=12, LINE_LEN=8, num_lines=1, spikes=4'b1111, lanes {7,0,-2,3} every beat → 8 result beats of {7,0,-2,3}; o_psum_last on beat 8; o_done 1 cycle later.
- num_lines=3, spikes=4'b0101, all lanes=5 → every beat {0,15,0,15}; o_sat_flag=0.
- PSUM_W=8, SATURATE=1, num_lines=20, spikes=4'b1111, lanes {7,-8,7,-8} → {127,-128,127,-128}; o_sat_flag=1. Same stimulus with SATURATE=0 → {-116,96,-116,96}; o_sat_flag=0.
- Case 2 with i_psum_ready pattern 1,0,1,0… → data held stable while stalled; 8 beats in order 0..7; no loss or duplication.
- Case 2 with random i_data_valid gaps (≈50% duty) and i_start pulsed mid-job → identical results; the mid-job start is ignored.
- Reset asserted during ACCUM (line 2, col 3), then num_lines=1, lanes all 1, spikes 4'b1111 → outputs {1,1,1,1}; no stale accumulation; o_sat_flag=0.
